ram_arbiter: RTL and testbench

- Shares the single 16-bit x 256-word RAM between two requesters: the CPU memory port and an auxiliary port (debug/display scanner or DMA).
- Accepts one transaction at a time. Registers the address, write-enable and write data, then drives the RAM read/write ports. Returns read data with a one-cycle ack pulse.
- Sits between the requesters and the RAM, replacing their direct RAM connection.
- Arbitration is round-robin by default, or fixed CPU priority when selected by parameter.

---
 rtl/ram_arb_pkg.sv | 14 +
 rtl/arb_pick2.sv | 22 ++
 rtl/ram_arbiter.sv | 106 ++++++++++
 tb/tb_ram_arbiter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// rtl/ram_arb_pkg.sv - shared state and owner encodings for the RAM arbiter
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_AUX = 1'b1;

endpackage

// File: rtl/arb_pick2.sv
// rtl/arb_pick2.sv - two-way request picker, round-robin or CPU-first on ties
module arb_pick2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       rr,
    output logic       winner,
    output logic       valid
);

    always_comb begin
        valid  = |req;
        winner = OWN_CPU;
        if (req == 2'b10) begin
            winner = OWN_AUX;
        end else if (req == 2'b11 && rr) begin
            winner = ~last;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// rtl/ram_arbiter.sv - shares one registered-output RAM between the CPU and aux ports
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int RR     = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              aux_req,
    input  logic              aux_we,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              aux_ack,
    output logic [DATA_W-1:0] aux_rdata,
    output logic [ADDR_W-1:0] ram_read_address,
    output logic [ADDR_W-1:0] ram_write_address,
    output logic              ram_write,
    output logic [DATA_W-1:0] ram_write_data,
    input  logic [DATA_W-1:0] ram_dout,
    output logic [1:0]        grant,
    output logic              busy
);

    state_t            state;
    logic              owner;
    logic              last_grant;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              pick_winner;
    logic              pick_valid;

    arb_pick2 u_pick (
        .req    ({aux_req, cpu_req}),
        .last   (last_grant),
        .rr     (RR != 0),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    // Write strobe depends on state so an asynchronous reset kills it immediately.
    assign ram_write         = (state == ACCESS) && lat_we;
    assign ram_read_address  = lat_addr;
    assign ram_write_address = lat_addr;
    assign ram_write_data    = lat_wdata;
    assign busy              = (state != IDLE);
    assign grant             = (state == IDLE) ? 2'b00 :
                               (owner == OWN_AUX) ? 2'b10 : 2'b01;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= OWN_CPU;
            last_grant <= OWN_AUX;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            cpu_ack    <= 1'b0;
            aux_ack    <= 1'b0;
            cpu_rdata  <= '0;
            aux_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner      <= pick_winner;
                        last_grant <= pick_winner;
                        lat_we     <= (pick_winner == OWN_AUX) ? aux_we    : cpu_we;
                        lat_addr   <= (pick_winner == OWN_AUX) ? aux_addr  : cpu_addr;
                        lat_wdata  <= (pick_winner == OWN_AUX) ? aux_wdata : cpu_wdata;
                        state      <= ACCESS;
                    end
                end
                ACCESS: begin
                    state <= RESP;
                end
                RESP: begin
                    // RAM output is valid here, one cycle after the address was presented.
                    if (owner == OWN_AUX) begin
                        aux_ack <= 1'b1;
                        if (!lat_we) aux_rdata <= ram_dout;
                    end else begin
                        cpu_ack <= 1'b1;
                        if (!lat_we) cpu_rdata <= ram_dout;
                    end
                    state <= DONE;
                end
                DONE: begin
                    cpu_ack <= 1'b0;
                    aux_ack <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb/tb_ram_arbiter.sv - directed bench for round-robin and fixed-priority arbiters
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cpu_req = 1'b0, cpu_we = 1'b0;
    logic [7:0]  cpu_addr = '0;
    logic [15:0] cpu_wdata = '0;
    logic        aux_req = 1'b0, aux_we = 1'b0;
    logic [7:0]  aux_addr = '0;
    logic [15:0] aux_wdata = '0;

    logic        cpu_ack0, aux_ack0, ram_write0, busy0;
    logic [15:0] cpu_rdata0, aux_rdata0, ram_write_data0, ram_dout0;
    logic [7:0]  ram_raddr0, ram_waddr0;
    logic [1:0]  grant0;

    logic        cpu_ack1, aux_ack1, ram_write1, busy1;
    logic [15:0] cpu_rdata1, aux_rdata1, ram_write_data1, ram_dout1;
    logic [7:0]  ram_raddr1, ram_waddr1;
    logic [1:0]  grant1;

    logic [15:0] mem0 [0:255];
    logic [15:0] mem1 [0:255];

    int total = 0;
    int bad = 0;
    logic u1_aux_seen = 1'b0;

    always #5 clk = ~clk;

    ram_arbiter #(.DATA_W(16), .ADDR_W(8), .RR(1)) u0 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack0), .cpu_rdata(cpu_rdata0),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_ack(aux_ack0), .aux_rdata(aux_rdata0),
        .ram_read_address(ram_raddr0), .ram_write_address(ram_waddr0),
        .ram_write(ram_write0), .ram_write_data(ram_write_data0), .ram_dout(ram_dout0),
        .grant(grant0), .busy(busy0)
    );

    ram_arbiter #(.DATA_W(16), .ADDR_W(8), .RR(0)) u1 (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack1), .cpu_rdata(cpu_rdata1),
        .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
        .aux_ack(aux_ack1), .aux_rdata(aux_rdata1),
        .ram_read_address(ram_raddr1), .ram_write_address(ram_waddr1),
        .ram_write(ram_write1), .ram_write_data(ram_write_data1), .ram_dout(ram_dout1),
        .grant(grant1), .busy(busy1)
    );

    always @(posedge clk) begin
        if (ram_write0) mem0[ram_waddr0] <= ram_write_data0;
        ram_dout0 <= mem0[ram_raddr0];
        if (ram_write1) mem1[ram_waddr1] <= ram_write_data1;
        ram_dout1 <= mem1[ram_raddr1];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (aux_ack1) u1_aux_seen = 1'b1;
    endtask

    task automatic cpu_write(input logic [7:0] a, input logic [15:0] d);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        step(); step(); step();
        cpu_req = 1'b0; cpu_we = 1'b0;
        step();
    endtask

    initial begin
        step(); step();
        check("rst_cpu_ack", cpu_ack0, 0);
        check("rst_aux_ack", aux_ack0, 0);
        check("rst_rdata", {cpu_rdata0, aux_rdata0}, 0);
        check("rst_grant", grant0, 0);
        check("rst_busy", busy0, 0);
        check("rst_ram_write", ram_write0, 0);
        check("rst_addr_data", {ram_waddr0, ram_raddr0, ram_write_data0}, 0);
        reset = 1'b0;

        // CPU-only write of BEEF to 05
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h05; cpu_wdata = 16'hBEEF;
        step();
        check("wr_access_we", ram_write0, 1);
        check("wr_access_grant", grant0, 2'b01);
        check("wr_access_busy", busy0, 1);
        check("wr_access_addr", ram_waddr0, 8'h05);
        check("wr_access_data", ram_write_data0, 16'hBEEF);
        step();
        check("wr_resp_we", ram_write0, 0);
        check("wr_resp_ack", cpu_ack0, 0);
        step();
        check("wr_done_ack", cpu_ack0, 1);
        check("wr_done_aux_ack", aux_ack0, 0);
        cpu_req = 1'b0;
        step();
        check("wr_idle_ack", cpu_ack0, 0);
        check("wr_idle_busy", busy0, 0);
        check("wr_mem", mem0[8'h05], 16'hBEEF);

        // CPU read back of 05
        cpu_req = 1'b1; cpu_we = 1'b0;
        step();
        check("rd_access_we", ram_write0, 0);
        check("rd_access_raddr", ram_raddr0, 8'h05);
        step(); step();
        check("rd_done_ack", cpu_ack0, 1);
        check("rd_done_rdata", cpu_rdata0, 16'hBEEF);
        check("rd_done_aux_ack", aux_ack0, 0);
        cpu_req = 1'b0;
        step();
        check("rd_idle_ack", cpu_ack0, 0);
        check("rd_rdata_held", cpu_rdata0, 16'hBEEF);

        cpu_write(8'h10, 16'h1111);
        cpu_write(8'h20, 16'h2222);
        cpu_write(8'h34, 16'h5555);
        cpu_write(8'h44, 16'h6666);

        // Simultaneous reads after reset: RR alternates, fixed priority stays on CPU
        reset = 1'b1;
        step();
        reset = 1'b0;
        u1_aux_seen = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        aux_req = 1'b1; aux_we = 1'b0; aux_addr = 8'h20;
        step();
        check("tie1_grant_rr", grant0, 2'b01);
        check("tie1_raddr", ram_raddr0, 8'h10);
        check("tie1_grant_fix", grant1, 2'b01);
        step(); step();
        check("tie1_cpu_ack", cpu_ack0, 1);
        check("tie1_cpu_rdata", cpu_rdata0, 16'h1111);
        check("tie1_aux_ack", aux_ack0, 0);
        step();
        check("tie1_idle_grant", grant0, 2'b00);
        step();
        check("tie2_grant_rr", grant0, 2'b10);
        check("tie2_raddr", ram_raddr0, 8'h20);
        check("tie2_grant_fix", grant1, 2'b01);
        step(); step();
        check("tie2_aux_ack", aux_ack0, 1);
        check("tie2_aux_rdata", aux_rdata0, 16'h2222);
        check("tie2_cpu_ack", cpu_ack0, 0);
        step(); step();
        check("tie3_grant_rr", grant0, 2'b01);
        check("tie3_grant_fix", grant1, 2'b01);
        step(); step();
        check("tie3_cpu_ack", cpu_ack0, 1);
        cpu_req = 1'b0; aux_req = 1'b0;
        step();
        check("fix_aux_never_acked", u1_aux_seen, 0);
        check("fix_cpu_rdata", cpu_rdata1, 16'h1111);

        // Request dropped and inputs changed after the grant
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 8'h33; cpu_wdata = 16'h1234;
        step();
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 8'h34; cpu_wdata = 16'hFFFF;
        check("drop_we", ram_write0, 1);
        check("drop_waddr", ram_waddr0, 8'h33);
        check("drop_wdata", ram_write_data0, 16'h1234);
        step();
        check("drop_resp_ack", cpu_ack0, 0);
        step();
        check("drop_done_ack", cpu_ack0, 1);
        step();
        check("drop_idle_ack", cpu_ack0, 0);
        check("drop_idle_busy", busy0, 0);
        check("drop_mem33", mem0[8'h33], 16'h1234);
        check("drop_mem34", mem0[8'h34], 16'h5555);

        // Reset asserted while an aux write is in ACCESS
        aux_req = 1'b1; aux_we = 1'b1; aux_addr = 8'h44; aux_wdata = 16'hDEAD;
        step();
        check("rw_grant", grant0, 2'b10);
        check("rw_we", ram_write0, 1);
        reset = 1'b1;
        #1;
        check("rw_async_we", ram_write0, 0);
        check("rw_grant_rst", grant0, 2'b00);
        check("rw_busy_rst", busy0, 0);
        check("rw_acks_rst", {cpu_ack0, aux_ack0}, 0);
        check("rw_rdata_rst", {cpu_rdata0, aux_rdata0}, 0);
        check("rw_addr_rst", {ram_waddr0, ram_write_data0}, 0);
        aux_req = 1'b0; aux_we = 1'b0;
        step();
        reset = 1'b0;
        check("rw_mem44", mem0[8'h44], 16'h6666);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h05;
        aux_req = 1'b1; aux_addr = 8'h20;
        step();
        check("rw_tie_grant", grant0, 2'b01);
        step(); step();
        check("rw_tie_ack", cpu_ack0, 1);
        check("rw_tie_rdata", cpu_rdata0, 16'hBEEF);
        cpu_req = 1'b0; aux_req = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
